addsub_digit_serial: RTL and testbench

Parametrised, multi-cycle adder/subtractor. It processes a WIDTH-bit operand pair DIGIT bits per clock, using one DIGIT-bit adder slice and a registered carry. It keeps the established control convention: `cntrl`=0 adds, `cntrl`=1 subtracts, implemented as y XOR `cntrl` with carry-in = `cntrl`. Operands enter and results leave through valid/ready handshakes, so the block sits between datapath stages that trade area for latency.

---
 rtl/addsub_digit_serial.sv | 187 ++++++++++++++++++
 tb/tb_addsub_digit_serial.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_digit_serial.sv
// -----------------------------------------------------------------------------
// addsub_digit_serial
//
// Multi-cycle adder/subtractor. A WIDTH-bit operand pair is processed DIGIT
// bits per clock through a single DIGIT-bit adder slice with a registered
// carry. cntrl=0 computes x+y; cntrl=1 computes x-y as x + ~y + 1.
// Operands are accepted and results returned via valid/ready handshakes.
//
// Parameters
//   WIDTH   operand/result width in bits
//   DIGIT   bits processed per cycle; must divide WIDTH exactly (N = WIDTH/DIGIT)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand pair and cntrl are valid
//   in_ready   block idle and able to accept an operation
//   x, y       augend/minuend and addend/subtrahend
//   cntrl      0 = add, 1 = subtract
//   out_valid  s and flags hold a completed result
//   out_ready  downstream accepts the result
//   s          result modulo 2^WIDTH
//   c_out      carry out of the MSB (on subtract: 1 means no borrow)
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
//   zero       s == 0
//
// Latency: acceptance edge E0, out_valid high after edge E0+N.
// Throughput with out_ready held high: one operation every N+2 cycles.
// -----------------------------------------------------------------------------
module addsub_digit_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cntrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // One DIGIT-bit slice of the ripple adder; MSB of the result is carry out.
    function automatic logic [DIGIT:0] digit_add(
        input logic [DIGIT-1:0] a,
        input logic [DIGIT-1:0] b,
        input logic             cin
    );
        return {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    endfunction

    // Control state
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    // Operand shift registers: the digit being processed is always at the
    // bottom, so no variable part-select is needed.
    logic [WIDTH-1:0] x_sh;
    logic [WIDTH-1:0] y_sh;
    logic             carry;

    // Result accumulator: each new digit enters at the top and shifts down,
    // so after N digits digit 0 sits in the least significant position.
    logic [WIDTH-1:0] acc;

    // Slice datapath
    logic [DIGIT-1:0] x_dig;
    logic [DIGIT-1:0] y_dig;
    logic [DIGIT:0]   add_res;
    logic [DIGIT-1:0] sum_dig;
    logic             carry_nxt;
    logic             msb_cin;
    logic [WIDTH-1:0] acc_nxt;
    logic             last_dig;

    logic accept;
    logic release_out;

    assign in_ready    = (state == ST_IDLE);
    assign out_valid   = (state == ST_DONE);
    assign accept      = in_valid && in_ready;
    assign release_out = out_valid && out_ready;

    always_comb begin
        x_dig     = x_sh[DIGIT-1:0];
        y_dig     = y_sh[DIGIT-1:0];
        add_res   = digit_add(x_dig, y_dig, carry);
        sum_dig   = add_res[DIGIT-1:0];
        carry_nxt = add_res[DIGIT];
        // Carry into the top bit of this slice, recovered from the sum bit:
        // sum = a ^ b ^ cin  =>  cin = a ^ b ^ sum. Only meaningful on the
        // last digit, where that bit is the word MSB.
        msb_cin   = x_dig[DIGIT-1] ^ y_dig[DIGIT-1] ^ sum_dig[DIGIT-1];
        acc_nxt   = (acc >> DIGIT) | (WIDTH'(sum_dig) << (WIDTH - DIGIT));
        last_dig  = (cnt == CNT_LAST);
    end

    // ---- Control: state and digit counter ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (last_dig) begin
                        state <= ST_DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (release_out) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // ---- Datapath: operands, carry, accumulator ----
    // Cleared on reset so an aborted operation leaves nothing behind.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_sh  <= '0;
            y_sh  <= '0;
            carry <= 1'b0;
            acc   <= '0;
        end else if (state == ST_IDLE) begin
            if (accept) begin
                x_sh  <= x;
                // Subtract as x + ~y + 1: invert y here, inject the +1 as carry-in.
                y_sh  <= y ^ {WIDTH{cntrl}};
                carry <= cntrl;
                acc   <= '0;
            end
        end else if (state == ST_RUN) begin
            x_sh  <= x_sh >> DIGIT;
            y_sh  <= y_sh >> DIGIT;
            carry <= carry_nxt;
            acc   <= acc_nxt;
        end
    end

    // ---- Result registers: loaded only on the edge that enters DONE ----
    // They keep the last completed result through IDLE and the next RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s     <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else if ((state == ST_RUN) && last_dig) begin
            s     <= acc_nxt;
            c_out <= carry_nxt;
            ovf   <= msb_cin ^ carry_nxt;
            zero  <= (acc_nxt == '0);
        end
    end

endmodule

// File: tb/tb_addsub_digit_serial.sv
module tb_addsub_digit_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic        cntrl;

    // Instance a: DIGIT=4 (N=4); instance b: DIGIT=16 (N=1). Shared inputs.
    logic        in_ready_a, out_valid_a, c_out_a, ovf_a, zero_a;
    logic [15:0] s_a;
    logic        in_ready_b, out_valid_b, c_out_b, ovf_b, zero_b;
    logic [15:0] s_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    addsub_digit_serial #(.WIDTH(16), .DIGIT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .x(x), .y(y), .cntrl(cntrl), .out_valid(out_valid_a), .out_ready(out_ready),
        .s(s_a), .c_out(c_out_a), .ovf(ovf_a), .zero(zero_a)
    );

    addsub_digit_serial #(.WIDTH(16), .DIGIT(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .x(x), .y(y), .cntrl(cntrl), .out_valid(out_valid_b), .out_ready(out_ready),
        .s(s_b), .c_out(c_out_b), .ovf(ovf_b), .zero(zero_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         output logic [15:0] es, output logic ec, output logic eo,
                         output logic ez);
        int ua, ub, ur, sa, sb, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            ur = ua - ub;
            sr = sa - sb;
            ec = (ua >= ub);
        end else begin
            ur = ua + ub;
            sr = sa + sb;
            ec = (ur > 65535);
        end
        es = 16'(ur & 32'hFFFF);
        eo = (sr > 32767) || (sr < -32768);
        ez = (es == 16'h0000);
    endtask

    task automatic check_both_result(input string tag, input logic [15:0] es,
                                     input logic ec, input logic eo, input logic ez);
        check({tag, ":s_a"}, s_a, es);
        check({tag, ":c_out_a"}, c_out_a, ec);
        check({tag, ":ovf_a"}, ovf_a, eo);
        check({tag, ":zero_a"}, zero_a, ez);
        check({tag, ":s_b"}, s_b, es);
        check({tag, ":c_out_b"}, c_out_b, ec);
        check({tag, ":ovf_b"}, ovf_b, eo);
        check({tag, ":zero_b"}, zero_b, ez);
    endtask

    // One full operation with out_ready high; measures latency of both instances.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic sub);
        logic [15:0] es;
        logic        ec, eo, ez;
        int          lat_a, lat_b;
        logic [15:0] ra, rb;
        logic        ca, oa, za, cb, ob, zb;
        model(a, b, sub, es, ec, eo, ez);
        ra = '0; rb = '0; ca = 0; oa = 0; za = 0; cb = 0; ob = 0; zb = 0;
        @(negedge clk);
        check({tag, ":in_ready_a"}, in_ready_a, 1);
        check({tag, ":in_ready_b"}, in_ready_b, 1);
        x = a; y = b; cntrl = sub; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        // Operands scrambled after acceptance must not matter.
        in_valid = 1'b0;
        x = 16'($urandom); y = 16'($urandom); cntrl = 1'($urandom);
        lat_a = -1;
        lat_b = -1;
        for (int k = 1; k <= 40 && (lat_a < 0 || lat_b < 0); k++) begin
            @(posedge clk); #1;
            if (out_valid_a && lat_a < 0) begin
                lat_a = k; ra = s_a; ca = c_out_a; oa = ovf_a; za = zero_a;
            end
            if (out_valid_b && lat_b < 0) begin
                lat_b = k; rb = s_b; cb = c_out_b; ob = ovf_b; zb = zero_b;
            end
        end
        check({tag, ":lat_a"}, lat_a, 4);
        check({tag, ":lat_b"}, lat_b, 1);
        check({tag, ":s_a"}, ra, es);
        check({tag, ":c_out_a"}, ca, ec);
        check({tag, ":ovf_a"}, oa, eo);
        check({tag, ":zero_a"}, za, ez);
        check({tag, ":s_b"}, rb, es);
        check({tag, ":c_out_b"}, cb, ec);
        check({tag, ":ovf_b"}, ob, eo);
        check({tag, ":zero_b"}, zb, ez);
        // Let instance a complete its output handshake.
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] es;
        logic        ec, eo, ez;
        int          waited;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; cntrl = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst:in_ready_a", in_ready_a, 1);
        check("rst:in_ready_b", in_ready_b, 1);
        check("rst:out_valid_a", out_valid_a, 0);
        check("rst:out_valid_b", out_valid_b, 0);
        check_both_result("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op("add", 16'h1234, 16'h0FFF, 1'b0);
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1);
        run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1);
        run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0);
        run_op("zero", 16'hABCD, 16'hABCD, 1'b1);
        run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0);
        run_op("sub_min", 16'h0000, 16'h8000, 1'b1);

        // Random cases
        for (int i = 0; i < 24; i++) begin
            run_op($sformatf("rnd%0d", i), 16'($urandom), 16'($urandom), 1'($urandom));
        end

        // Backpressure: hold out_ready low in DONE while offering new operands
        model(16'h4321, 16'h1111, 1'b1, es, ec, eo, ez);
        @(negedge clk);
        x = 16'h4321; y = 16'h1111; cntrl = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        waited = 0;
        while (!(out_valid_a && out_valid_b) && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("bp:reach_done", (out_valid_a && out_valid_b), 1);
        check_both_result("bp:initial", es, ec, eo, ez);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x = 16'($urandom); y = 16'($urandom); cntrl = 1'($urandom);
            @(posedge clk); #1;
            check($sformatf("bp%0d:out_valid_a", i), out_valid_a, 1);
            check($sformatf("bp%0d:out_valid_b", i), out_valid_b, 1);
            check($sformatf("bp%0d:in_ready_a", i), in_ready_a, 0);
            check($sformatf("bp%0d:in_ready_b", i), in_ready_b, 0);
            check($sformatf("bp%0d:s_a", i), s_a, es);
            check($sformatf("bp%0d:s_b", i), s_b, es);
        end
        check_both_result("bp:held", es, ec, eo, ez);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_rel:in_ready_a", in_ready_a, 1);
        check("bp_rel:in_ready_b", in_ready_b, 1);
        check("bp_rel:out_valid_a", out_valid_a, 0);
        check("bp_rel:out_valid_b", out_valid_b, 0);
        check("bp_rel:s_a", s_a, es);

        // Reset mid-RUN: instance a is processing cnt=2 at the reset edge
        @(negedge clk);
        x = 16'h5A5A; y = 16'h1234; cntrl = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;          // acceptance edge E0
        in_valid = 1'b0;
        @(posedge clk);              // E0+1: cnt 0 processed
        @(posedge clk); #1;          // E0+2: cnt now 2
        check("rmid:a_busy", in_ready_a, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;          // reset edge
        check("rmid:in_ready_a", in_ready_a, 1);
        check("rmid:in_ready_b", in_ready_b, 1);
        check("rmid:out_valid_a", out_valid_a, 0);
        check("rmid:out_valid_b", out_valid_b, 0);
        check("rmid:s_a", s_a, 16'h0000);
        check("rmid:s_b", s_b, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        // Confirm no stray completion from the aborted operation
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("rmid:no_out_a", out_valid_a, 0);
        check("rmid:no_out_b", out_valid_b, 0);
        run_op("after_rst", 16'h0001, 16'h0001, 1'b0);

        // Reset while holding a result in DONE
        @(negedge clk);
        x = 16'h00FF; y = 16'h0001; cntrl = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        check("rdone:pre_a", out_valid_a, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rdone:out_valid_a", out_valid_a, 0);
        check("rdone:s_a", s_a, 16'h0000);
        check("rdone:in_ready_a", in_ready_a, 1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        run_op("after_rdone", 16'h7000, 16'h9000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
